vram_arbiter: RTL and testbench

Single-port video RAM arbiter for the vdp99 display processor. Each clock it grants one VRAM access, to either the display fetch engine (pattern/name/colour reads paced by the vgasync counters) or the host CPU port (reads and writes). Display fetches have priority, but a bounded-wait rule guarantees CPU service. The block also drives the synchronous block-RAM port.

---
 rtl/vram_arbiter_if.sv | 40 ++++
 rtl/vram_arbiter.sv | 115 +++++++++++
 tb/tb_vram_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus: display fetch, CPU port and block-RAM port.
// slave = arbiter side, master = requesters plus RAM side.
interface vram_arbiter_if #(
    parameter int AW = 14,
    parameter int DW = 8
);
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_gnt;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_addr,
        output disp_gnt, disp_rvalid, disp_rdata,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output disp_req, disp_addr,
        input  disp_gnt, disp_rvalid, disp_rdata,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch priority, bounded CPU wait.
// Ports: clk, reset (sync, active-low), bus (vram_arbiter_if.slave).
module vram_arbiter #(
    parameter int AW           = 14,
    parameter int DW           = 8,
    parameter int CPU_MAX_WAIT = 3
) (
    input  logic           clk,
    input  logic           reset,
    vram_arbiter_if.slave  bus
);
    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_ISSUED = 2'd1;
    localparam logic [1:0] C_DATA   = 2'd2;

    localparam logic [1:0] T_NONE = 2'd0;
    localparam logic [1:0] T_DISP = 2'd1;
    localparam logic [1:0] T_CPU  = 2'd2;

    localparam logic [3:0] MAXW = 4'(CPU_MAX_WAIT);

    logic [1:0]    state_q, state_d;
    logic [3:0]    wait_q, wait_d;
    logic [1:0]    tag1_q, tag1_d;
    logic [1:0]    tag2_q;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] drd_q, crd_q;

    logic cpu_pend;
    logic force_cpu;
    logic cpu_grant;
    logic disp_grant;

    always_comb begin
        cpu_pend   = bus.cpu_req && (state_q == C_IDLE);
        force_cpu  = cpu_pend && (wait_q == MAXW);
        // Grants are suppressed while reset is held.
        cpu_grant  = reset && cpu_pend
                   && (!bus.disp_req || force_cpu);
        disp_grant = reset && bus.disp_req && !cpu_grant;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE:   if (cpu_grant) state_d = C_ISSUED;
            C_ISSUED: state_d = C_DATA;
            C_DATA:   state_d = C_IDLE;
            default:  state_d = C_IDLE;
        endcase
    end

    always_comb begin
        wait_d = wait_q;
        if (!cpu_pend || cpu_grant) begin
            wait_d = 4'd0;
        end else if (disp_grant && wait_q < MAXW) begin
            wait_d = wait_q + 4'd1;
        end
    end

    // Idle cycles keep the address and data bus stable.
    always_comb begin
        addr_d  = addr_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        tag1_d  = T_NONE;
        if (cpu_grant) begin
            addr_d  = bus.cpu_addr;
            we_d    = bus.cpu_we;
            wdata_d = bus.cpu_wdata;
            tag1_d  = T_CPU;
        end else if (disp_grant) begin
            addr_d  = bus.disp_addr;
            tag1_d  = T_DISP;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= C_IDLE;
            wait_q  <= 4'd0;
            tag1_q  <= T_NONE;
            tag2_q  <= T_NONE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            drd_q   <= '0;
            crd_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            tag1_q  <= tag1_d;
            tag2_q  <= tag1_q;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            // RAM returns data while the access is on the bus.
            if (tag1_q == T_DISP) drd_q <= bus.mem_rdata;
            if (tag1_q == T_CPU)  crd_q <= bus.mem_rdata;
        end
    end

    assign bus.disp_gnt    = disp_grant;
    assign bus.disp_rvalid = (tag2_q == T_DISP);
    assign bus.disp_rdata  = drd_q;
    assign bus.cpu_ack     = (state_q == C_DATA);
    assign bus.cpu_rdata   = crd_q;
    assign bus.mem_addr    = addr_q;
    // A write still on the bus when reset arrives never reaches RAM.
    assign bus.mem_we      = we_q && reset;
    assign bus.mem_wdata   = wdata_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural RAM.
// Ports: none; drives clk, reset and a vram_arbiter_if.
module tb_vram_arbiter;
    localparam int AW   = 14;
    localparam int DW   = 8;
    localparam int MAXW = 3;

    typedef struct {
        int         due;
        logic [7:0] data;
        bit         chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    vram_arbiter #(
        .AW(AW), .DW(DW), .CPU_MAX_WAIT(MAXW)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(bus)
    );

    logic [7:0] ram [16384];
    logic [7:0] ref_ram [16384];

    // RAM presents data for the registered address during the access.
    assign bus.mem_rdata = ram[bus.mem_addr];
    always @(posedge clk)
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    exp_t dq[$];
    exp_t cq[$];
    exp_t mon_e;
    int rv_cnt = 0;
    int ack_cnt = 0;
    int we_cnt = 0;

    always @(negedge clk) begin
        if (bus.disp_rvalid) begin
            rv_cnt++;
            chk("disp_expected", dq.size() > 0, 1);
            if (dq.size() > 0) begin
                mon_e = dq.pop_front();
                chk("disp_latency", cyc, mon_e.due);
                chk("disp_rdata", bus.disp_rdata, mon_e.data);
            end
        end
        if (bus.cpu_ack) begin
            ack_cnt++;
            chk("cpu_expected", cq.size() > 0, 1);
            if (cq.size() > 0) begin
                mon_e = cq.pop_front();
                chk("cpu_latency", cyc, mon_e.due);
                if (mon_e.chk)
                    chk("cpu_rdata", bus.cpu_rdata, mon_e.data);
            end
        end
        if (dq.size() > 0) chk("disp_overdue", dq[0].due < cyc, 0);
        if (cq.size() > 0) chk("cpu_overdue", cq[0].due < cyc, 0);
        if (bus.mem_we) we_cnt++;
    end

    // Stimulus staged for the next cycle.
    logic          s_rst = 1'b0;
    logic          s_dreq = 1'b0;
    logic [AW-1:0] s_daddr = '0;
    logic          s_creq = 1'b0;
    logic          s_cwe = 1'b0;
    logic [AW-1:0] s_caddr = '0;
    logic [DW-1:0] s_cwd = '0;

    // Reference model state: what the access schedule should be.
    int            busy = 0;
    int            refused = 0;
    bit            pw_v = 0;
    logic [AW-1:0] pw_addr;
    logic [DW-1:0] pw_data;
    bit            exp_v = 0;
    logic [AW-1:0] exp_addr;
    logic          exp_we;
    logic [DW-1:0] exp_wd;
    bit            g_cpu = 0;
    bit            g_disp = 0;
    bit            ack_now = 0;
    bit            pend;
    bit            frc;
    logic          dut_dg;

    task automatic tick();
        @(negedge clk);
        rst_n         = s_rst;
        bus.disp_req  = s_dreq;
        bus.disp_addr = s_daddr;
        bus.cpu_req   = s_creq;
        bus.cpu_we    = s_cwe;
        bus.cpu_addr  = s_caddr;
        bus.cpu_wdata = s_cwd;
        #1;
        ack_now = 0;
        if (!rst_n) begin
            chk("rst_disp_gnt", bus.disp_gnt, 0);
            chk("rst_mem_we", bus.mem_we, 0);
            dq.delete();
            cq.delete();
            busy = 0;
            refused = 0;
            pw_v = 0;
            exp_v = 0;
            g_cpu = 0;
            g_disp = 0;
        end else begin
            if (exp_v) begin
                chk("mem_we", bus.mem_we, exp_we);
                chk("mem_addr", bus.mem_addr, exp_addr);
                if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wd);
            end else begin
                chk("mem_idle_we", bus.mem_we, 0);
            end
            if (pw_v) ref_ram[pw_addr] = pw_data;
            pw_v = 0;
            ack_now = (busy == 1);
            pend = s_creq && (busy == 0);
            frc = pend && (refused == MAXW);
            g_cpu = pend && (!s_dreq || frc);
            g_disp = s_dreq && !g_cpu;
            chk("disp_gnt", bus.disp_gnt, g_disp);
            exp_v = g_cpu || g_disp;
            if (g_cpu) begin
                exp_addr = s_caddr;
                exp_we = s_cwe;
                exp_wd = s_cwd;
                cq.push_back('{cyc + 2, ref_ram[s_caddr], !s_cwe});
                if (s_cwe) begin
                    pw_v = 1;
                    pw_addr = s_caddr;
                    pw_data = s_cwd;
                end
                busy = 3;
            end else if (g_disp) begin
                exp_addr = s_daddr;
                exp_we = 1'b0;
                dq.push_back('{cyc + 2, ref_ram[s_daddr], 1'b1});
            end
            if (!pend || g_cpu) refused = 0;
            else if (g_disp && refused < MAXW) refused++;
        end
        dut_dg = bus.disp_gnt;
        @(posedge clk);
        if (busy > 0) busy--;
    endtask

    task automatic settle();
        for (int i = 0; i < 12; i++) begin
            tick();
            if (g_disp) s_dreq = 1'b0;
            if (ack_now) s_creq = 1'b0;
        end
        s_dreq = 1'b0;
        s_creq = 1'b0;
        repeat (3) tick();
    endtask

    task automatic cpu_access();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack_now) begin
                s_creq = 1'b0;
                break;
            end
        end
        s_creq = 1'b0;
    endtask

    int n;
    int k;
    int a0;
    int w0;

    initial begin
        for (int i = 0; i < 16384; i++) begin
            ram[i] = 8'(i);
            ref_ram[i] = 8'(i);
        end

        // Reset held with both requesters active.
        s_rst = 1'b0;
        s_dreq = 1'b1;
        s_daddr = 14'h0010;
        s_creq = 1'b1;
        s_caddr = 14'h0020;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("rst_mem_addr", bus.mem_addr, 0);
            chk("rst_mem_wdata", bus.mem_wdata, 0);
            chk("rst_disp_rvalid", bus.disp_rvalid, 0);
            chk("rst_disp_rdata", bus.disp_rdata, 0);
            chk("rst_cpu_ack", bus.cpu_ack, 0);
            chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        end
        s_rst = 1'b1;
        tick();
        chk("first_grant_disp", dut_dg, 1);
        settle();

        // Display stream 0x0100..0x0104.
        a0 = rv_cnt;
        s_dreq = 1'b1;
        s_daddr = 14'h0100;
        n = 0;
        for (int i = 0; i < 20 && n < 5; i++) begin
            tick();
            if (g_disp) begin
                n++;
                s_daddr = s_daddr + 14'd1;
            end
        end
        s_dreq = 1'b0;
        settle();
        chk("stream_rvalids", rv_cnt - a0, 5);

        // CPU write then read at the top address.
        w0 = we_cnt;
        s_creq = 1'b1;
        s_cwe = 1'b1;
        s_caddr = 14'h3FFF;
        s_cwd = 8'hA5;
        cpu_access();
        settle();
        chk("write_pulses", we_cnt - w0, 1);
        s_creq = 1'b1;
        s_cwe = 1'b0;
        cpu_access();
        #1;
        chk("read_back_a5", bus.cpu_rdata, 8'hA5);
        settle();

        // Starvation under continuous display requests.
        s_dreq = 1'b1;
        s_daddr = 14'h0200;
        repeat (3) begin
            tick();
            s_daddr = 14'($urandom);
        end
        s_creq = 1'b1;
        s_cwe = 1'b0;
        s_caddr = 14'h0123;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!dut_dg) break;
            k++;
            s_daddr = 14'($urandom);
        end
        chk("starve_refusals", k, MAXW);
        tick();
        chk("disp_resume", dut_dg, 1);
        s_dreq = 1'b0;
        settle();

        // Held request: one access per three-cycle loop.
        a0 = ack_cnt;
        s_creq = 1'b1;
        s_cwe = 1'b0;
        s_caddr = 14'h0200;
        repeat (9) tick();
        s_creq = 1'b0;
        chk("held_acks", ack_cnt - a0, 3);
        settle();

        // Reset the cycle after a write grant.
        s_creq = 1'b1;
        s_cwe = 1'b1;
        s_caddr = 14'h0055;
        s_cwd = 8'h3C;
        tick();
        chk("rst_wr_granted", g_cpu, 1);
        s_rst = 1'b0;
        s_creq = 1'b0;
        w0 = we_cnt;
        a0 = ack_cnt;
        tick();
        s_rst = 1'b1;
        repeat (4) tick();
        chk("rst_wr_no_we", we_cnt - w0, 0);
        chk("rst_wr_no_ack", ack_cnt - a0, 0);
        chk("rst_wr_ram", ram[14'h0055], 8'h55);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (!s_dreq || g_disp) begin
                s_dreq = ($urandom_range(0, 9) < 7);
                s_daddr = 14'h3FE0 | 14'($urandom_range(0, 31));
            end
            if (ack_now) s_creq = 1'b0;
            if (!s_creq && $urandom_range(0, 3) == 0) begin
                s_creq = 1'b1;
                s_cwe = 1'($urandom);
                s_caddr = 14'h3FE0 | 14'($urandom_range(0, 31));
                s_cwd = 8'($urandom);
            end
            s_rst = ($urandom_range(0, 299) != 0);
            tick();
        end
        s_rst = 1'b1;
        settle();
        repeat (4) tick();
        chk("disp_queue_empty", dq.size(), 0);
        chk("cpu_queue_empty", cq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
